// File: rtl/phy_pkg.sv
// Shared PHY receive definitions: K28.5 comma codes and the comma lock state encoding.
// Also used by the 8b/10b decoder.
package phy_pkg;

    localparam logic [9:0] COM_RD_NEG = 10'b0011111010;
    localparam logic [9:0] COM_RD_POS = 10'b1100000101;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } lock_state_e;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/comma_offset_search.sv
// Combinational K28.5 search over every bit offset of a two-symbol window.
// Reports whether any offset matches and the lowest matching offset.
module comma_offset_search
    import phy_pkg::*;
#(
    parameter int unsigned SYMBOL_W = 10,
    parameter int unsigned RD_MODE  = 2
) (
    input  logic [2*SYMBOL_W-1:0] window,
    output logic                  hit,
    output logic [3:0]            hit_k
);

    localparam logic [SYMBOL_W-1:0] NEG = SYMBOL_W'(COM_RD_NEG);
    localparam logic [SYMBOL_W-1:0] POS = SYMBOL_W'(COM_RD_POS);
    localparam bit MATCH_NEG = (RD_MODE != 1);
    localparam bit MATCH_POS = (RD_MODE != 0);

    logic [SYMBOL_W-1:0] slice;

    always_comb begin
        hit   = 1'b0;
        hit_k = '0;
        slice = '0;
        // Scan from the top offset down so the lowest matching offset is left standing.
        for (int k = SYMBOL_W - 1; k >= 0; k--) begin
            slice = window[2*SYMBOL_W-1-k -: SYMBOL_W];
            if ((MATCH_NEG && slice == NEG) || (MATCH_POS && slice == POS)) begin
                hit   = 1'b1;
                hit_k = 4'(k);
            end
        end
    end

endmodule

// File: rtl/comma_align_lock.sv
// Comma alignment and lock: qualifies repeated K28.5 commas at a stable bit offset and
// presents byte-aligned symbols while locked.
module comma_align_lock
    import phy_pkg::*;
#(
    parameter int unsigned SYMBOL_W   = 10,
    parameter int unsigned LOCK_COUNT = 2,
    parameter int unsigned LOSS_COUNT = 4,
    parameter int unsigned RD_MODE    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SYMBOL_W-1:0] detect_comma,
    output logic [SYMBOL_W-1:0] Data_aligned,
    output logic                RxValid,
    output logic                Comma_pulse,
    output logic [3:0]          Lock_offset,
    output logic                Lock_lost
);

    localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_N = 4'(LOSS_COUNT);

    logic [SYMBOL_W-1:0]   cur_q, prev_q;
    logic [2*SYMBOL_W-1:0] window;
    logic                  hit;
    logic [3:0]            hit_k;

    lock_state_e state_q, state_d;
    logic [3:0]  cand_q, cand_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  miss_q, miss_d;
    logic        pulse_q, pulse_d;
    logic        lost_q, lost_d;

    logic [SYMBOL_W-1:0] aligned;
    logic [SYMBOL_W-1:0] data_q;

    assign window = {prev_q, cur_q};

    comma_offset_search #(
        .SYMBOL_W (SYMBOL_W),
        .RD_MODE  (RD_MODE)
    ) u_search (
        .window (window),
        .hit    (hit),
        .hit_k  (hit_k)
    );

    always_comb begin
        aligned = '0;
        for (int k = 0; k < SYMBOL_W; k++) begin
            if (cand_q == 4'(k)) begin
                aligned = window[2*SYMBOL_W-1-k -: SYMBOL_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        miss_d  = miss_q;
        pulse_d = 1'b0;
        lost_d  = 1'b0;
        unique case (state_q)
            UNLOCKED: begin
                if (hit) begin
                    cand_d = hit_k;
                    cnt_d  = 4'd1;
                    if (LOCK_N == 4'd1) begin
                        state_d = LOCKED;
                        miss_d  = '0;
                        pulse_d = 1'b1;
                    end else begin
                        state_d = ACQUIRE;
                    end
                end
            end
            ACQUIRE: begin
                if (hit) begin
                    if (hit_k == cand_q) begin
                        cnt_d   = sat_inc4(cnt_q);
                        pulse_d = 1'b1;
                        if (cnt_d >= LOCK_N) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                        end
                    end else begin
                        cand_d = hit_k;
                        cnt_d  = 4'd1;
                    end
                end
            end
            LOCKED: begin
                if (hit) begin
                    if (hit_k == cand_q) begin
                        miss_d  = '0;
                        pulse_d = 1'b1;
                    end else begin
                        miss_d = sat_inc4(miss_q);
                        // The comma that trips the loss is not reused to start acquisition.
                        if (miss_d >= LOSS_N) begin
                            state_d = UNLOCKED;
                            lost_d  = 1'b1;
                            cnt_d   = '0;
                            miss_d  = '0;
                        end
                    end
                end
            end
            default: state_d = UNLOCKED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q   <= '0;
            prev_q  <= '0;
            state_q <= UNLOCKED;
            cand_q  <= '0;
            cnt_q   <= '0;
            miss_q  <= '0;
            pulse_q <= 1'b0;
            lost_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            cur_q   <= detect_comma;
            prev_q  <= cur_q;
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            miss_q  <= miss_d;
            pulse_q <= pulse_d;
            lost_q  <= lost_d;
            data_q  <= aligned;
        end
    end

    assign Data_aligned = data_q;
    assign RxValid      = (state_q == LOCKED);
    assign Comma_pulse  = pulse_q;
    assign Lock_offset  = cand_q;
    assign Lock_lost    = lost_q;

endmodule

// File: tb/tb_comma_align_lock.sv
// Bench for comma_align_lock: a serial bit stream is chopped into symbols and fed to three
// differently parameterised instances, each checked against a behavioural lock model.
module tb_comma_align_lock;

    localparam int W     = 10;
    localparam int N_DUT = 3;
    localparam logic [9:0] NEG   = 10'b0011111010;
    localparam logic [9:0] POS   = 10'b1100000101;
    localparam logic [9:0] SYM_A = 10'h0FA;
    localparam logic [9:0] SYM_B = 10'h096;
    localparam logic [9:0] SYM_P = 10'h305;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] detect_comma = '0;

    logic [9:0]  da [N_DUT];
    logic        rv [N_DUT];
    logic        cp [N_DUT];
    logic [3:0]  lo [N_DUT];
    logic        ll [N_DUT];
    logic [16:0] obs [N_DUT];

    always #5 clk = ~clk;

    comma_align_lock #(.SYMBOL_W(10), .LOCK_COUNT(2), .LOSS_COUNT(4), .RD_MODE(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .detect_comma(detect_comma), .Data_aligned(da[0]),
        .RxValid(rv[0]), .Comma_pulse(cp[0]), .Lock_offset(lo[0]), .Lock_lost(ll[0]));
    comma_align_lock #(.SYMBOL_W(10), .LOCK_COUNT(2), .LOSS_COUNT(4), .RD_MODE(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .detect_comma(detect_comma), .Data_aligned(da[1]),
        .RxValid(rv[1]), .Comma_pulse(cp[1]), .Lock_offset(lo[1]), .Lock_lost(ll[1]));
    comma_align_lock #(.SYMBOL_W(10), .LOCK_COUNT(1), .LOSS_COUNT(1), .RD_MODE(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .detect_comma(detect_comma), .Data_aligned(da[2]),
        .RxValid(rv[2]), .Comma_pulse(cp[2]), .Lock_offset(lo[2]), .Lock_lost(ll[2]));

    for (genvar g = 0; g < N_DUT; g++) begin : g_obs
        assign obs[g] = {da[g], rv[g], cp[g], lo[g], ll[g]};
    end

    int lock_n [N_DUT] = '{2, 2, 1};
    int loss_n [N_DUT] = '{4, 4, 1};
    int rd_n   [N_DUT] = '{2, 0, 1};

    // Model state: phase 0 = searching, 1 = qualifying, 2 = locked.
    int          ph [N_DUT];
    int          cand [N_DUT];
    int          cnt [N_DUT];
    int          miss [N_DUT];
    logic [16:0] exp_o [N_DUT];
    logic [9:0]  m_prev, m_cur, h0, h1, h2;
    bit          bits [$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;

    function automatic int find_comma(input logic [19:0] w, input int rd);
        logic [9:0] s;
        for (int k = 0; k < W; k++) begin
            s = 10'(w >> (W - k));
            if ((s == NEG && rd != 1) || (s == POS && rd != 0)) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_DUT; i++) begin
            ph[i] = 0; cand[i] = 0; cnt[i] = 0; miss[i] = 0; exp_o[i] = '0;
        end
        m_prev = '0; m_cur = '0; h0 = '0; h1 = '0; h2 = '0;
    endtask

    task automatic model_edge(input logic [9:0] sym);
        logic [19:0] w;
        logic [9:0]  al;
        int          k;
        logic        p, l;
        w = {m_prev, m_cur};
        for (int i = 0; i < N_DUT; i++) begin
            k  = find_comma(w, rd_n[i]);
            al = 10'(w >> (W - cand[i]));
            p  = 1'b0;
            l  = 1'b0;
            if (k >= 0) begin
                if (ph[i] == 0) begin
                    cand[i] = k;
                    cnt[i]  = 1;
                    if (lock_n[i] == 1) begin ph[i] = 2; p = 1'b1; end
                    else ph[i] = 1;
                end else if (k == cand[i]) begin
                    p = 1'b1;
                    if (ph[i] == 1) begin
                        cnt[i] = (cnt[i] < 15) ? cnt[i] + 1 : 15;
                        if (cnt[i] >= lock_n[i]) begin ph[i] = 2; miss[i] = 0; end
                    end else begin
                        miss[i] = 0;
                    end
                end else if (ph[i] == 1) begin
                    cand[i] = k;
                    cnt[i]  = 1;
                end else begin
                    miss[i] = (miss[i] < 15) ? miss[i] + 1 : 15;
                    if (miss[i] >= loss_n[i]) begin
                        ph[i] = 0; l = 1'b1; cnt[i] = 0; miss[i] = 0;
                    end
                end
            end
            exp_o[i] = {al, ph[i] == 2, p, 4'(cand[i]), l};
        end
        m_prev = m_cur;
        m_cur  = sym;
    endtask

    task automatic push_bits(input logic [9:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) bits.push_back(v[i]);
    endtask

    task automatic push_sym(input logic [9:0] v);
        push_bits(v, W);
    endtask

    task automatic step(input logic [9:0] sym);
        detect_comma = sym;
        @(posedge clk);
        model_edge(sym);
        h2 = h1; h1 = h0; h0 = sym;
        cyc++;
        #1;
    endtask

    task automatic step_word();
        logic [9:0] s;
        s = '0;
        for (int i = 0; i < W; i++) s = {s[8:0], bits.pop_front()};
        step(s);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        detect_comma = '0;
        bits.delete();
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        detect_comma = SYM_A;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < N_DUT; i++) begin
            n_cmp++;
            if (obs[i] !== '0) begin
                n_fail++;
                $display("FAIL reset dut%0d: got %h, want 0", i, obs[i]);
            end
        end
        bits.delete();
        model_reset();
        rst_n = 1'b1;
        repeat (3) begin
            step(10'h000);
            for (int i = 0; i < N_DUT; i++) begin
                n_cmp++;
                if (obs[i] !== exp_o[i]) begin
                    n_fail++;
                    $display("FAIL reset_idle dut%0d: got %h, want %h", i, obs[i], exp_o[i]);
                end
            end
        end
    endtask

    task automatic test_aligned();
        int   n_com, com2, rise;
        logic prev_rv, pulse_at_rise;
        apply_reset();
        n_com = 0; com2 = -1; rise = -1; prev_rv = 1'b0; pulse_at_rise = 1'b0;
        for (int j = 0; j < 8; j++) push_sym((j % 2 == 0) ? SYM_A : SYM_B);
        while (bits.size() >= W) begin
            step_word();
            if (h0 == SYM_A) begin n_com++; if (n_com == 2) com2 = cyc; end
            if (rv[0] && !prev_rv && rise < 0) begin rise = cyc; pulse_at_rise = cp[0]; end
            prev_rv = rv[0];
            for (int i = 0; i < N_DUT; i++) begin
                n_cmp++;
                if (obs[i] !== exp_o[i]) begin
                    n_fail++;
                    $display("FAIL aligned c%0d dut%0d: got %h, want %h", cyc, i, obs[i], exp_o[i]);
                end
            end
            if (rv[0]) begin
                n_cmp++;
                if (da[0] !== h2) begin
                    n_fail++;
                    $display("FAIL aligned_delay c%0d: got %h, want %h", cyc, da[0], h2);
                end
            end
        end
        n_cmp++;
        if (rise != com2 + 2 || pulse_at_rise !== 1'b1) begin
            n_fail++;
            $display("FAIL aligned_rise: rise %0d pulse %b, want %0d pulse 1",
                     rise, pulse_at_rise, com2 + 2);
        end
        n_cmp++;
        if (rv[0] !== 1'b1 || lo[0] !== 4'd0) begin
            n_fail++;
            $display("FAIL aligned_lock: valid %b offset %0d, want 1 / 0", rv[0], lo[0]);
        end
    endtask

    task automatic test_shifted();
        apply_reset();
        push_bits(10'b101, 3);
        for (int j = 0; j < 12; j++) push_sym((j % 2 == 0) ? SYM_A : SYM_B);
        push_sym(SYM_B);
        push_sym(SYM_B);
        while (bits.size() >= W) begin
            step_word();
            for (int i = 0; i < N_DUT; i++) begin
                n_cmp++;
                if (obs[i] !== exp_o[i]) begin
                    n_fail++;
                    $display("FAIL shifted c%0d dut%0d: got %h, want %h", cyc, i, obs[i], exp_o[i]);
                end
            end
            if (rv[0]) begin
                n_cmp++;
                if (da[0] !== SYM_A && da[0] !== SYM_B) begin
                    n_fail++;
                    $display("FAIL shifted_data c%0d: got %h, want 0fa or 096", cyc, da[0]);
                end
            end
        end
        n_cmp++;
        if (rv[0] !== 1'b1 || lo[0] !== 4'd3) begin
            n_fail++;
            $display("FAIL shifted_lock: valid %b offset %0d, want 1 / 3", rv[0], lo[0]);
        end
    endtask

    task automatic test_realign_loss();
        int n_lost;
        apply_reset();
        for (int j = 0; j < 6; j++) push_sym((j % 2 == 0) ? SYM_A : SYM_B);
        n_lost = 0;
        for (int phase = 0; phase < 3; phase++) begin
            if (phase == 1) begin
                push_bits(10'b01010, 5);
                for (int j = 0; j < 8; j++) push_sym((j % 2 == 0) ? SYM_A : SYM_B);
                push_sym(SYM_B);
                push_sym(SYM_B);
            end else if (phase == 2) begin
                for (int j = 0; j < 4; j++) push_sym((j % 2 == 0) ? SYM_A : SYM_B);
                push_sym(SYM_B);
                push_sym(SYM_B);
            end
            while (bits.size() >= W) begin
                step_word();
                if (ll[0]) n_lost++;
                for (int i = 0; i < N_DUT; i++) begin
                    n_cmp++;
                    if (obs[i] !== exp_o[i]) begin
                        n_fail++;
                        $display("FAIL realign c%0d dut%0d: got %h, want %h",
                                 cyc, i, obs[i], exp_o[i]);
                    end
                end
            end
            n_cmp++;
            if (phase == 0 && (rv[0] !== 1'b1 || lo[0] !== 4'd0)) begin
                n_fail++;
                $display("FAIL realign_lock0: valid %b offset %0d, want 1 / 0", rv[0], lo[0]);
            end else if (phase == 1 && (rv[0] !== 1'b0 || n_lost != 1)) begin
                n_fail++;
                $display("FAIL realign_loss: valid %b lost %0d, want 0 / 1", rv[0], n_lost);
            end else if (phase == 2 && (rv[0] !== 1'b1 || lo[0] !== 4'd5)) begin
                n_fail++;
                $display("FAIL realign_relock: valid %b offset %0d, want 1 / 5", rv[0], lo[0]);
            end
        end
    endtask

    task automatic test_acq_restart();
        logic any_rv;
        apply_reset();
        any_rv = 1'b0;
        for (int phase = 0; phase < 3; phase++) begin
            if (phase == 0) push_bits(10'b01, 2);
            if (phase == 1) push_bits(10'b01010, 5);
            push_sym(SYM_A);
            push_sym(SYM_B);
            push_sym(SYM_B);
            while (bits.size() >= W) begin
                step_word();
                any_rv = any_rv | rv[0];
                for (int i = 0; i < N_DUT; i++) begin
                    n_cmp++;
                    if (obs[i] !== exp_o[i]) begin
                        n_fail++;
                        $display("FAIL acq c%0d dut%0d: got %h, want %h", cyc, i, obs[i], exp_o[i]);
                    end
                end
            end
            n_cmp++;
            if (phase < 2 && (any_rv !== 1'b0 || lo[0] !== ((phase == 0) ? 4'd2 : 4'd7))) begin
                n_fail++;
                $display("FAIL acq_nolock p%0d: valid %b offset %0d", phase, any_rv, lo[0]);
            end else if (phase == 2 && (rv[0] !== 1'b1 || lo[0] !== 4'd7)) begin
                n_fail++;
                $display("FAIL acq_lock: valid %b offset %0d, want 1 / 7", rv[0], lo[0]);
            end
        end
    endtask

    task automatic test_rd_filter();
        apply_reset();
        for (int j = 0; j < 8; j++) push_sym(SYM_P);
        while (bits.size() >= W) begin
            step_word();
            for (int i = 0; i < N_DUT; i++) begin
                n_cmp++;
                if (obs[i] !== exp_o[i]) begin
                    n_fail++;
                    $display("FAIL rd c%0d dut%0d: got %h, want %h", cyc, i, obs[i], exp_o[i]);
                end
            end
            n_cmp++;
            if (rv[1] !== 1'b0 || cp[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL rd_neg_only c%0d: valid %b pulse %b, want 0 / 0", cyc, rv[1], cp[1]);
            end
        end
        n_cmp++;
        if (rv[0] !== 1'b1 || rv[2] !== 1'b1 || lo[0] !== 4'd0) begin
            n_fail++;
            $display("FAIL rd_pos_lock: valid %b/%b offset %0d, want 1/1 0", rv[0], rv[2], lo[0]);
        end
    endtask

    task automatic test_reset_midlock();
        int   n_com, com2, rise;
        logic prev_rv, pulse_at_rise;
        apply_reset();
        for (int j = 0; j < 6; j++) push_sym((j % 2 == 0) ? SYM_A : SYM_B);
        while (bits.size() >= W) step_word();
        n_cmp++;
        if (rv[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL midlock_pre: valid %b, want 1", rv[0]);
        end
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < N_DUT; i++) begin
            n_cmp++;
            if (obs[i] !== '0) begin
                n_fail++;
                $display("FAIL midlock_async dut%0d: got %h, want 0", i, obs[i]);
            end
        end
        bits.delete();
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_com = 0; com2 = -1; rise = -1; prev_rv = 1'b0; pulse_at_rise = 1'b0;
        for (int j = 0; j < 6; j++) push_sym((j % 2 == 0 && j < 4) ? SYM_A : SYM_B);
        while (bits.size() >= W) begin
            step_word();
            if (h0 == SYM_A) begin n_com++; if (n_com == 2) com2 = cyc; end
            if (rv[0] && !prev_rv && rise < 0) begin rise = cyc; pulse_at_rise = cp[0]; end
            prev_rv = rv[0];
            for (int i = 0; i < N_DUT; i++) begin
                n_cmp++;
                if (obs[i] !== exp_o[i]) begin
                    n_fail++;
                    $display("FAIL midlock c%0d dut%0d: got %h, want %h", cyc, i, obs[i], exp_o[i]);
                end
            end
        end
        n_cmp++;
        if (rise != com2 + 2 || pulse_at_rise !== 1'b1) begin
            n_fail++;
            $display("FAIL midlock_relock: rise %0d pulse %b, want %0d pulse 1",
                     rise, pulse_at_rise, com2 + 2);
        end
    endtask

    task automatic test_random();
        int steps;
        int r;
        apply_reset();
        steps = 0;
        while (steps < 600) begin
            r = int'($urandom_range(0, 19));
            if (r < 6) push_sym(($urandom_range(0, 1) == 1) ? NEG : POS);
            else if (r == 6) push_bits(10'($urandom), int'($urandom_range(1, 9)));
            else push_sym(10'($urandom));
            while (bits.size() >= W) begin
                step_word();
                steps++;
                for (int i = 0; i < N_DUT; i++) begin
                    n_cmp++;
                    if (obs[i] !== exp_o[i]) begin
                        n_fail++;
                        $display("FAIL random c%0d dut%0d: got %h, want %h",
                                 cyc, i, obs[i], exp_o[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_aligned();
        test_shifted();
        test_realign_loss();
        test_acq_restart();
        test_rd_filter();
        test_reset_midlock();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
